// File: rtl/delay_pipe.sv
// Runtime-selectable delay line with per-sample valid, clock enable, flush and safe delay switching.
// Optional zero-latency bypass for del_sel = 0 is enabled by defining DELAY_PIPE_BYPASS_EN.
module delay_pipe #(
    parameter int WIDTH   = 8,
    parameter int MAX_DEL = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ce,
    input  logic                               flush,
    input  logic [$clog2(MAX_DEL+1)-1:0]       del_sel,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               din_valid,
    output logic [WIDTH-1:0]                   dout,
    output logic                               dout_valid,
    output logic                               busy
);

    localparam int SEL_W = $clog2(MAX_DEL + 1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEL);

    logic [WIDTH-1:0] data_q [MAX_DEL];
    logic [MAX_DEL-1:0] valid_q;
    logic [SEL_W-1:0] del_q, del_d;
    logic [SEL_W-1:0] settle_q, settle_d;
    logic [SEL_W-1:0] n_sel;
    logic [WIDTH-1:0] tap_data;
    logic             tap_valid;

    // Effective delay: del_sel clamped into the legal range.
    always_comb begin
        n_sel = del_sel;
        if (del_sel > MAX_SEL) begin
            n_sel = MAX_SEL;
        end
`ifdef DELAY_PIPE_BYPASS_EN
        // Zero is legal here and selects the combinational bypass.
`else
        if (del_sel == '0) begin
            n_sel = SEL_W'(1);
        end
`endif
    end

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        del_d    = del_q;
        settle_d = settle_q;
        if (n_sel != del_q) begin
            del_d    = n_sel;
            settle_d = n_sel;
`ifdef DELAY_PIPE_BYPASS_EN
            // Entering or leaving bypass waits for the longer of the two delays.
            if (((n_sel == '0) || (del_q == '0)) && (del_q > n_sel)) begin
                settle_d = del_q;
            end
`endif
        end else if ((settle_q != '0) && ce) begin
            settle_d = settle_q - SEL_W'(1);
        end
        if (flush) begin
            settle_d = '0;
        end
    end

    // NOTE: the data words are reset too, because dout must read 0 right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEL; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (ce) begin
            data_q[0]  <= din;
            valid_q[0] <= din_valid;
            for (int i = 1; i < MAX_DEL; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            del_q    <= MAX_SEL;
            settle_q <= '0;
        end else begin
            del_q    <= del_d;
            settle_q <= settle_d;
        end
    end

    // Output tap selected by the registered delay, never by del_sel directly.
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < MAX_DEL; i++) begin
            if (del_q == SEL_W'(i + 1)) begin
                tap_data  = data_q[i];
                tap_valid = valid_q[i];
            end
        end
`ifdef DELAY_PIPE_BYPASS_EN
        if (del_q == '0) begin
            tap_data  = din;
            tap_valid = din_valid;
        end
`endif
    end

    assign dout       = tap_data;
    assign dout_valid = tap_valid && (settle_q == '0);
    assign busy       = (settle_q != '0);

endmodule

// File: tb/tb_delay_pipe.sv
// Directed self-checking bench for delay_pipe (WIDTH=8, MAX_DEL=8).
// Covers reset, fixed delay, stall, delay switching, clamp, flush and the del_sel=0 behaviour.
module tb_delay_pipe;

    localparam int WIDTH   = 8;
    localparam int MAX_DEL = 8;
    localparam int SEL_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             flush;
    logic [SEL_W-1:0] del_sel;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;

    int total = 0;
    int bad   = 0;

    delay_pipe #(.WIDTH(WIDTH), .MAX_DEL(MAX_DEL)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .flush      (flush),
        .del_sel    (del_sel),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock edge and settle just past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b1; flush = 1'b0; del_sel = 4'd8;
        din = 8'hAA; din_valid = 1'b1;
        tick();
        tick();
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; din_valid = 1'b0; din = 8'h00;
    endtask

    task automatic test_fixed_delay;
        logic [7:0] exp_d;
        del_sel = 4'd3;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fixed_busy_change got=%b exp=1", busy); end
        repeat (3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fixed_busy_settled got=%b exp=0", busy); end
        for (int k = 0; k < 16; k++) begin
            din = 8'(k); din_valid = 1'b1;
            tick();
            total++;
            if (dout_valid !== (k >= 2)) begin
                bad++; $display("FAIL fixed_valid k=%0d got=%b exp=%b", k, dout_valid, (k >= 2));
            end
            if (k >= 2) begin
                exp_d = 8'(k - 2);
                total++; if (dout !== exp_d) begin bad++; $display("FAIL fixed_data k=%0d got=%h exp=%h", k, dout, exp_d); end
            end
        end
    endtask

    task automatic test_stall;
        int         m;
        logic [7:0] exp_d;
        logic       exp_v;
        del_sel = 4'd4; din_valid = 1'b0;
        repeat (5) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_settle_busy got=%b exp=0", busy); end
        m = 0; exp_d = 8'h00; exp_v = 1'b0;
        for (int s = 0; s < 20; s++) begin
            if (s >= 6 && s <= 10) begin
                ce = 1'b0; din = 8'hEE; din_valid = 1'b1;
            end else begin
                ce = 1'b1; din = 8'h40 + 8'(m); din_valid = 1'b1;
            end
            tick();
            if (ce) begin
                exp_v = (m >= 3);
                if (m >= 3) exp_d = 8'h40 + 8'(m - 3);
                m++;
            end
            total++; if (dout_valid !== exp_v) begin bad++; $display("FAIL stall_valid s=%0d got=%b exp=%b", s, dout_valid, exp_v); end
            if (exp_v) begin
                total++; if (dout !== exp_d) begin bad++; $display("FAIL stall_data s=%0d got=%h exp=%h", s, dout, exp_d); end
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_delay_change;
        int         m;
        logic [7:0] exp_d;
        del_sel = 4'd2;
        for (int i = 0; i < 6; i++) begin
            din = 8'h70 + 8'(i); din_valid = 1'b1;
            tick();
        end
        // 2 -> 6 while streaming
        for (int j = 0; j < 14; j++) begin
            del_sel = 4'd6; din = 8'h80 + 8'(j); din_valid = 1'b1;
            tick();
            total++; if (busy !== (j <= 5)) begin bad++; $display("FAIL chg6_busy j=%0d got=%b exp=%b", j, busy, (j <= 5)); end
            total++; if (dout_valid !== (j > 5)) begin bad++; $display("FAIL chg6_valid j=%0d got=%b exp=%b", j, dout_valid, (j > 5)); end
            if (j > 5) begin
                exp_d = 8'h80 + 8'(j - 5);
                total++; if (dout !== exp_d) begin bad++; $display("FAIL chg6_data j=%0d got=%h exp=%h", j, dout, exp_d); end
            end
        end
        // 6 -> 2 with a stall inside the settling window
        m = 0;
        for (int s = 0; s < 8; s++) begin
            del_sel = 4'd2;
            if (s == 1 || s == 2) begin
                ce = 1'b0; din = 8'hEE;
            end else begin
                ce = 1'b1; din = 8'hC0 + 8'(m);
            end
            din_valid = 1'b1;
            tick();
            if (!ce) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL chg2_stall_busy s=%0d got=%b exp=1", s, busy); end
                total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL chg2_stall_valid s=%0d got=%b exp=0", s, dout_valid); end
            end else begin
                total++; if (busy !== (m < 2)) begin bad++; $display("FAIL chg2_busy s=%0d got=%b exp=%b", s, busy, (m < 2)); end
                total++; if (dout_valid !== (m >= 2)) begin bad++; $display("FAIL chg2_valid s=%0d got=%b exp=%b", s, dout_valid, (m >= 2)); end
                if (m >= 2) begin
                    exp_d = 8'hC0 + 8'(m - 1);
                    total++; if (dout !== exp_d) begin bad++; $display("FAIL chg2_data s=%0d got=%h exp=%h", s, dout, exp_d); end
                end
                m++;
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_clamp_flush;
        logic [7:0] exp_d;
        for (int m = 0; m < 11; m++) begin
            del_sel = 4'd15; din = 8'h10 + 8'(m); din_valid = 1'b1;
            tick();
            total++; if (busy !== (m < 8)) begin bad++; $display("FAIL clamp_busy m=%0d got=%b exp=%b", m, busy, (m < 8)); end
            total++; if (dout_valid !== (m >= 8)) begin bad++; $display("FAIL clamp_valid m=%0d got=%b exp=%b", m, dout_valid, (m >= 8)); end
            if (m >= 8) begin
                exp_d = 8'h10 + 8'(m - 7);
                total++; if (dout !== exp_d) begin bad++; $display("FAIL clamp_data m=%0d got=%h exp=%h", m, dout, exp_d); end
            end
        end
        flush = 1'b1; din = 8'hF0; din_valid = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", dout_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
        for (int k = 1; k <= 8; k++) begin
            din = 8'h20 + 8'(k); din_valid = 1'b1;
            tick();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL postflush_busy k=%0d got=%b exp=0", k, busy); end
            total++; if (dout_valid !== (k == 8)) begin bad++; $display("FAIL postflush_valid k=%0d got=%b exp=%b", k, dout_valid, (k == 8)); end
            if (k == 8) begin
                total++; if (dout !== 8'h21) begin bad++; $display("FAIL postflush_data got=%h exp=21", dout); end
            end
        end
    endtask

    task automatic test_bypass;
`ifdef DELAY_PIPE_BYPASS_EN
        del_sel = 4'd0; din_valid = 1'b0; din = 8'h00;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bypass_busy_change got=%b exp=1", busy); end
        repeat (7) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bypass_busy_late got=%b exp=1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bypass_busy_settled got=%b exp=0", busy); end
        din = 8'h5A; din_valid = 1'b1;
        #1;
        total++; if (dout !== 8'h5A) begin bad++; $display("FAIL bypass_data got=%h exp=5a", dout); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b exp=1", dout_valid); end
        din = 8'hA5; din_valid = 1'b0;
        #1;
        total++; if (dout !== 8'hA5) begin bad++; $display("FAIL bypass_data2 got=%h exp=a5", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL bypass_valid2 got=%b exp=0", dout_valid); end
`else
        for (int m = 0; m < 6; m++) begin
            del_sel = 4'd0; din = 8'h30 + 8'(m); din_valid = 1'b1;
            tick();
            total++; if (busy !== (m == 0)) begin bad++; $display("FAIL sel0_busy m=%0d got=%b exp=%b", m, busy, (m == 0)); end
            total++; if (dout_valid !== (m >= 1)) begin bad++; $display("FAIL sel0_valid m=%0d got=%b exp=%b", m, dout_valid, (m >= 1)); end
            if (m >= 1) begin
                total++; if (dout !== 8'h30 + 8'(m)) begin bad++; $display("FAIL sel0_data m=%0d got=%h exp=%h", m, dout, 8'h30 + 8'(m)); end
            end
        end
        din = 8'h99;
        #1;
        total++; if (dout !== 8'h35) begin bad++; $display("FAIL sel0_registered got=%h exp=35", dout); end
`endif
    endtask

    task automatic test_reset_midstream;
        del_sel = 4'd5; din = 8'h66; din_valid = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_pre got=%b exp=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL midrst_dout got=%h exp=00", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", dout_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; flush = 1'b0; del_sel = 4'd8;
        din = 8'h00; din_valid = 1'b0;
        test_reset();
        test_fixed_delay();
        test_stall();
        test_delay_change();
        test_clamp_flush();
        test_bypass();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
